// File: rtl/prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl
//
// Run controller for the FEC processor core. Each falling edge of start
// launches the next program (round-robin over NPROG programs). It loads the
// PC with the program base address, runs until the decoder reports a halt
// instruction or the watchdog expires, retires the pipeline during a short
// drain window, and then raises ack. A rising edge of start either
// acknowledges a finished program or aborts one in flight.
//
// Optional feature (compile-time macro PROG_RUN_CTRL_CYCCNT_EN):
//   When defined, adds output run_cycles, the RUN cycle count of the last
//   completed or aborted run.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   start        in   bench level; fall = launch request, rise = ack / abort
//   halt_insn    in   decoder flag: current instruction is a halt
//   pc_load      out  one-cycle pulse: PC loads pc_load_val
//   pc_load_val  out  [A-1:0] program base address (prog_idx * PROG_STRIDE)
//   pc_hold      out  PC holds its value
//   run_en       out  enables register-file and data-memory writes
//   ack          out  program complete (level)
//   timeout      out  last run ended by the watchdog; sticky until next launch
//   prog_idx     out  [1:0] index of the current or last program
//   run_cycles   out  [11:0] (macro only) RUN cycles of the last run
//
// Handshake: start is a level owned by the bench. Only its sampled edges
// matter: a fall in IDLE launches; a rise in DONE acknowledges; a rise in
// LAUNCH/RUN/DRAIN aborts. Sub-cycle glitches are not seen.
// -----------------------------------------------------------------------------
module prog_run_ctrl #(
    parameter int A            = 10,
    parameter int NPROG        = 3,
    parameter int PROG_STRIDE  = 256,
    parameter int MAX_CYCLES   = 4095,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         halt_insn,
    output logic         pc_load,
    output logic [A-1:0] pc_load_val,
    output logic         pc_hold,
    output logic         run_en,
    output logic         ack,
    output logic         timeout,
    output logic [1:0]   prog_idx
`ifdef PROG_RUN_CTRL_CYCCNT_EN
    ,
    output logic [11:0]  run_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         start_q;
    logic         fall;
    logic         rise;
    logic [11:0]  cyc_cnt;
    logic [11:0]  cyc_cnt_next;
    logic [11:0]  cyc_inc;
    logic [2:0]   drain_cnt;
    logic [2:0]   drain_cnt_next;
    logic [1:0]   idx_next;
    logic         timeout_next;
    logic         pc_load_next;
    logic         pc_hold_next;
    logic         run_en_next;
    logic         ack_next;
    logic [A-1:0] pc_load_val_next;

    assign fall    = start_q & ~start;
    assign rise    = ~start_q & start;
    assign cyc_inc = cyc_cnt + 12'd1;

    // Next-state logic. Every output is a flop loaded from a decode of the
    // next state, so outputs change on the same edge as the state.
    always_comb begin
        state_next     = state;
        cyc_cnt_next   = cyc_cnt;
        drain_cnt_next = drain_cnt;
        idx_next       = prog_idx;
        timeout_next   = timeout;

        case (state)
            IDLE: begin
                // A rise here is meaningless and is ignored.
                if (fall) begin
                    state_next   = LAUNCH;
                    cyc_cnt_next = 12'd0;
                    timeout_next = 1'b0;
                end
            end
            LAUNCH: begin
                if (rise) state_next = IDLE;
                else      state_next = RUN;
            end
            RUN: begin
                // cyc_inc counts the current RUN cycle, so the watchdog
                // ends the run after exactly MAX_CYCLES RUN cycles.
                cyc_cnt_next = cyc_inc;
                if (rise) begin
                    state_next = IDLE;
                end else if (halt_insn) begin
                    // Halt takes priority over a watchdog hit in the same cycle.
                    state_next     = DRAIN;
                    drain_cnt_next = 3'd0;
                    timeout_next   = 1'b0;
                end else if (cyc_inc == 12'(MAX_CYCLES)) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 3'd0;
                    timeout_next   = 1'b1;
                end
            end
            DRAIN: begin
                if (rise) begin
                    state_next = IDLE;
                end else if (drain_cnt == 3'(DRAIN_CYCLES - 1)) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt + 3'd1;
                end
            end
            DONE: begin
                if (rise) begin
                    state_next = IDLE;
                    idx_next   = (prog_idx == 2'(NPROG - 1)) ? 2'd0 : prog_idx + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode of the next state.
    always_comb begin
        pc_load_next     = (state_next == LAUNCH);
        pc_hold_next     = !((state_next == LAUNCH) || (state_next == RUN));
        run_en_next      = (state_next == RUN) || (state_next == DRAIN);
        ack_next         = (state_next == DONE);
        pc_load_val_next = A'(idx_next) * A'(PROG_STRIDE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            prog_idx    <= 2'd0;
            cyc_cnt     <= 12'd0;
            drain_cnt   <= 3'd0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            pc_hold     <= 1'b1;
            run_en      <= 1'b0;
            ack         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            start_q     <= start;
            prog_idx    <= idx_next;
            cyc_cnt     <= cyc_cnt_next;
            drain_cnt   <= drain_cnt_next;
            pc_load     <= pc_load_next;
            pc_load_val <= pc_load_val_next;
            pc_hold     <= pc_hold_next;
            run_en      <= run_en_next;
            ack         <= ack_next;
            timeout     <= timeout_next;
        end
    end

`ifdef PROG_RUN_CTRL_CYCCNT_EN
    // Captured when RUN is left for any reason (halt, watchdog, abort);
    // cleared when the next program launches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cycles <= 12'd0;
        end else if (state == RUN && state_next != RUN) begin
            run_cycles <= cyc_inc;
        end else if (state_next == LAUNCH && state != LAUNCH) begin
            run_cycles <= 12'd0;
        end
    end
`endif

endmodule

// File: tb/tb_prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_run_ctrl
//
// Bench for prog_run_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge. Expected base addresses and expected timeout flags are
// queued when a launch or a run ending is driven, and popped when the DUT
// reports pc_load or ack.
// -----------------------------------------------------------------------------
module tb_prog_run_ctrl;
    localparam int A     = 10;
    localparam int NPROG = 3;
    localparam int STRD  = 256;
    localparam int MAXC  = 4095;
    localparam int DRN   = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         halt_insn;
    logic         pc_load;
    logic [A-1:0] pc_load_val;
    logic         pc_hold;
    logic         run_en;
    logic         ack;
    logic         timeout;
    logic [1:0]   prog_idx;
`ifdef PROG_RUN_CTRL_CYCCNT_EN
    logic [11:0]  run_cycles;
`endif

    prog_run_ctrl #(
        .A(A), .NPROG(NPROG), .PROG_STRIDE(STRD),
        .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt_insn(halt_insn),
        .pc_load(pc_load),
        .pc_load_val(pc_load_val),
        .pc_hold(pc_hold),
        .run_en(run_en),
        .ack(ack),
        .timeout(timeout),
        .prog_idx(prog_idx)
`ifdef PROG_RUN_CTRL_CYCCNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           errors = 0;
    int           checks = 0;
    int           exp_idx = 0;
    logic [A-1:0] exp_q[$];
    logic         exp_to_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive a fall on start and wait (bounded) for the pc_load pulse.
    // Returns sitting at the falling edge of the first RUN cycle.
    task automatic do_launch();
        int lat;
        logic [A-1:0] v;
        v = A'(exp_idx * STRD);
        exp_q.push_back(v);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_load) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check("pc_load_seen", 32'(0), 32'(1));
        end else begin
            check("launch_latency", 32'(lat), 32'(0));
            check("pc_load_val", 32'(pc_load_val), 32'(exp_q.pop_front()));
            check("launch_idx", 32'(prog_idx), 32'(exp_idx));
            check("launch_timeout", 32'(timeout), 32'(0));
            check("launch_run_en", 32'(run_en), 32'(0));
        end
        @(negedge clk);
        check("run1_run_en", 32'(run_en), 32'(1));
        check("run1_pc_hold", 32'(pc_hold), 32'(0));
        check("run1_pc_load", 32'(pc_load), 32'(0));
    endtask

    // Starting at the DRAIN cycle 1 falling edge: DRN drain cycles, then ack.
    task automatic drain_and_ack();
        for (int d = 0; d < DRN; d++) begin
            check("drain_pc_hold", 32'(pc_hold), 32'(1));
            check("drain_run_en", 32'(run_en), 32'(1));
            check("drain_ack", 32'(ack), 32'(0));
            @(negedge clk);
        end
        check("done_ack", 32'(ack), 32'(1));
        check("done_run_en", 32'(run_en), 32'(0));
        check("done_pc_hold", 32'(pc_hold), 32'(1));
        check("done_timeout", 32'(timeout), 32'(exp_to_q.pop_front()));
    endtask

    // Starting at RUN cycle 1: raise halt_insn during RUN cycle n.
    task automatic run_halt(input int n);
        bit ok;
        ok = 1'b1;
        for (int c = 1; c < n; c++) begin
            if (!(run_en && !pc_hold)) ok = 1'b0;
            @(negedge clk);
        end
        check("run_window", 32'(ok), 32'(1));
        halt_insn = 1'b1;
        exp_to_q.push_back(1'b0);
        @(negedge clk);
        halt_insn = 1'b0;
        drain_and_ack();
    endtask

    // Starting at RUN cycle 1: let the watchdog expire, optionally with a
    // halt on the last allowed RUN cycle.
    task automatic run_watchdog(input bit halt_at_limit);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!(run_en && !pc_hold)) break;
            cnt++;
            if (halt_at_limit && cnt == MAXC) halt_insn = 1'b1;
            @(negedge clk);
            halt_insn = 1'b0;
        end
        check("run_length", 32'(cnt), 32'(MAXC));
        exp_to_q.push_back(halt_at_limit ? 1'b0 : 1'b1);
        drain_and_ack();
    endtask

    task automatic release_ack();
        start = 1'b1;
        exp_idx = (exp_idx + 1) % NPROG;
        @(negedge clk);
        check("rel_ack", 32'(ack), 32'(0));
        check("rel_idx", 32'(prog_idx), 32'(exp_idx));
        check("rel_run_en", 32'(run_en), 32'(0));
        check("rel_pc_hold", 32'(pc_hold), 32'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b0;
        start     = 1'b1;
        halt_insn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc_hold", 32'(pc_hold), 32'(1));
        check("rst_run_en", 32'(run_en), 32'(0));
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_pc_load", 32'(pc_load), 32'(0));
        check("rst_idx", 32'(prog_idx), 32'(0));
`ifdef PROG_RUN_CTRL_CYCCNT_EN
        check("rst_run_cycles", 32'(run_cycles), 32'(0));
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", 32'(pc_hold), 32'(1));

        // Program 0 with a halt on RUN cycle 20.
        do_launch();
        run_halt(20);
`ifdef PROG_RUN_CTRL_CYCCNT_EN
        check("run_cycles_20", 32'(run_cycles), 32'(20));
`endif
        release_ack();
        @(negedge clk);

        // Programs 1 and 2 with random halt positions.
        for (int p = 0; p < 2; p++) begin
            do_launch();
            run_halt($urandom_range(1, 30));
            release_ack();
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Wrap back to program 0, which runs into the watchdog.
        do_launch();
        run_watchdog(1'b0);
        release_ack();
        @(negedge clk);

        // Program 1: launch clears timeout (checked in do_launch), then abort.
        do_launch();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("abort_run_en", 32'(run_en), 32'(0));
        check("abort_ack", 32'(ack), 32'(0));
        check("abort_idx", 32'(prog_idx), 32'(exp_idx));
        check("abort_pc_hold", 32'(pc_hold), 32'(1));
        check("abort_timeout", 32'(timeout), 32'(0));
        @(negedge clk);

        // Program 1 again: halt coinciding with the watchdog limit.
        do_launch();
        run_watchdog(1'b1);
        release_ack();
        @(negedge clk);

        // Program 2, asynchronous reset in the middle of DRAIN.
        do_launch();
        repeat (4) @(negedge clk);
        halt_insn = 1'b1;
        @(negedge clk);
        halt_insn = 1'b0;
        check("pre_reset_drain", 32'(run_en & pc_hold), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("areset_run_en", 32'(run_en), 32'(0));
        check("areset_pc_hold", 32'(pc_hold), 32'(1));
        check("areset_idx", 32'(prog_idx), 32'(0));
        check("areset_pc_val", 32'(pc_load_val), 32'(0));
        check("areset_timeout", 32'(timeout), 32'(0));
`ifdef PROG_RUN_CTRL_CYCCNT_EN
        check("areset_run_cycles", 32'(run_cycles), 32'(0));
`endif
        #1 reset = 1'b1;
        exp_idx = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 32'(run_en), 32'(0));
        do_launch();
        run_halt(3);
        release_ack();

        check("sb_addr_empty", 32'(exp_q.size()), 32'(0));
        check("sb_to_empty", 32'(exp_to_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "simulation time limit");
    end

endmodule
